// File: rtl/spi_slave_duplex.sv
// Full-duplex SPI slave: oversampled, glitch-filtered SPI clock, all four modes, any word width.
// Define SPI_SLAVE_DUPLEX_TX_EN to build the transmit path (TX buffer, shift register, MISO, OE).
module spi_slave_duplex #(
  parameter int WIDTH  = 8,
  parameter int FILTER = 3,
  parameter bit CPOL   = 1'b0,
  parameter bit CPHA   = 1'b0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             SPI_CLK,
  input  logic             SPI_MOSI,
  input  logic             SPI_CS,
  output logic             SPI_MISO,
  output logic             SPI_MISO_OE,
  output logic [WIDTH-1:0] RX_DATA,
  output logic             RX_VALID,
  input  logic [WIDTH-1:0] TX_DATA,
  input  logic             TX_LOAD,
  output logic             TX_READY
);
  localparam int CW  = $clog2(WIDTH);
  localparam int FCW = $clog2(FILTER + 1);

  logic [1:0]        sclk_sync_reg, mosi_sync_reg, cs_sync_reg;
  logic [FILTER-1:0] mosi_pipe_reg, cs_pipe_reg;
  logic              filt_state_reg, lead_stb_reg, trail_stb_reg;
  logic [FCW-1:0]    filt_cnt_reg;
  logic [CW-1:0]     bit_cnt_reg;
  logic [WIDTH-1:0]  rx_shift_reg, rx_data_reg;
  logic              rx_valid_reg;
  logic              cs_aligned, mosi_aligned, selected, sample_stb, word_done;

  // MOSI/CS get FILTER extra stages so they line up with the filtered clock strobes.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sclk_sync_reg <= {2{CPOL}};
      mosi_sync_reg <= 2'b00;
      cs_sync_reg   <= 2'b11;
      mosi_pipe_reg <= '0;
      cs_pipe_reg   <= '1;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[0], SPI_CLK};
      mosi_sync_reg <= {mosi_sync_reg[0], SPI_MOSI};
      cs_sync_reg   <= {cs_sync_reg[0], SPI_CS};
      mosi_pipe_reg[0] <= mosi_sync_reg[1];
      cs_pipe_reg[0]   <= cs_sync_reg[1];
      for (int i = 1; i < FILTER; i++) begin
        mosi_pipe_reg[i] <= mosi_pipe_reg[i-1];
        cs_pipe_reg[i]   <= cs_pipe_reg[i-1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      filt_state_reg <= CPOL;
      filt_cnt_reg   <= '0;
      lead_stb_reg   <= 1'b0;
      trail_stb_reg  <= 1'b0;
    end else begin
      lead_stb_reg  <= 1'b0;
      trail_stb_reg <= 1'b0;
      if (sclk_sync_reg[1] == filt_state_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_cnt_reg == FCW'(FILTER - 1)) begin
        filt_state_reg <= sclk_sync_reg[1];
        filt_cnt_reg   <= '0;
        lead_stb_reg   <= (sclk_sync_reg[1] != CPOL);
        trail_stb_reg  <= (sclk_sync_reg[1] == CPOL);
      end else begin
        filt_cnt_reg <= filt_cnt_reg + 1'b1;
      end
    end
  end

  assign cs_aligned   = cs_pipe_reg[FILTER-1];
  assign mosi_aligned = mosi_pipe_reg[FILTER-1];
  assign selected     = !cs_aligned;
  assign sample_stb   = selected && (CPHA ? trail_stb_reg : lead_stb_reg);
  assign word_done    = sample_stb && (bit_cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      bit_cnt_reg  <= '0;
      rx_shift_reg <= '0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
    end else begin
      rx_valid_reg <= word_done;
      if (!selected) begin
        bit_cnt_reg  <= '0;
        rx_shift_reg <= '0;
      end else if (sample_stb) begin
        rx_shift_reg <= {rx_shift_reg[WIDTH-2:0], mosi_aligned};
        if (word_done) begin
          rx_data_reg <= {rx_shift_reg[WIDTH-2:0], mosi_aligned};
          bit_cnt_reg <= '0;
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign RX_DATA  = rx_data_reg;
  assign RX_VALID = rx_valid_reg;

`ifdef SPI_SLAVE_DUPLEX_TX_EN
  logic [WIDTH-1:0] tx_buf_reg, tx_shift_reg;
  logic             tx_full_reg, skip_reg, cs_prev_reg;
  logic             shift_stb, word_start;

  assign shift_stb  = selected && (CPHA ? lead_stb_reg : trail_stb_reg);
  assign word_start = (cs_prev_reg && !cs_aligned) || word_done;

  // skip_reg suppresses one shift: the first leading edge (CPHA=1) or the
  // trailing edge right after a completed word (CPHA=0), both of which would drop the fresh MSB.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      tx_buf_reg   <= '0;
      tx_shift_reg <= '0;
      tx_full_reg  <= 1'b0;
      skip_reg     <= 1'b0;
      cs_prev_reg  <= 1'b1;
    end else begin
      cs_prev_reg <= cs_aligned;
      if (word_start) begin
        if (tx_full_reg) begin
          tx_shift_reg <= tx_buf_reg;
          tx_full_reg  <= 1'b0;
        end else begin
          tx_shift_reg <= TX_LOAD ? TX_DATA : '0;
        end
        skip_reg <= CPHA ? 1'b1 : word_done;
      end else if (shift_stb) begin
        if (!skip_reg) tx_shift_reg <= {tx_shift_reg[WIDTH-2:0], 1'b0};
        skip_reg <= 1'b0;
      end
      if (TX_LOAD && !tx_full_reg && !word_start) begin
        tx_buf_reg  <= TX_DATA;
        tx_full_reg <= 1'b1;
      end
    end
  end

  assign SPI_MISO    = tx_shift_reg[WIDTH-1];
  assign SPI_MISO_OE = selected;
  assign TX_READY    = !tx_full_reg;
`else
  logic unused_tx;
  assign unused_tx   = ^{TX_DATA, TX_LOAD};
  assign SPI_MISO    = 1'b0;
  assign SPI_MISO_OE = 1'b0;
  assign TX_READY    = 1'b0;
`endif
endmodule
